// File: rtl/ipg_pkg.sv
// Shared opcodes, reply codes, reply field offsets and FSM encodings for the IPG reply engine.
package ipg_pkg;

  localparam logic [7:0] OP_READ   = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_ECHO   = 8'h03;

  localparam logic [7:0] ACK_WRITE = 8'h82;
  localparam logic [7:0] ACK_ECHO  = 8'h83;
  localparam logic [7:0] ERR       = 8'hFF;

  localparam int LEN_MSB = 519;
  localparam int LEN_LSB = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EXEC,
    ST_MEMRD,
    ST_MEMWR,
    ST_REPLY
  } state_t;

  typedef enum logic [1:0] {
    DEC_ERR,
    DEC_READ,
    DEC_WRITE,
    DEC_ECHO
  } dec_t;

endpackage

// File: rtl/ipg_word_ram.sv
// Single-port synchronous word RAM with registered (read-first) output.
module ipg_word_ram #(
  parameter int MEM_DEPTH  = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ipg_reply_engine.sv
// Assembles IPG request chunks into a message, executes it against a word RAM and holds the reply.
// Build macro IPG_REPLY_ECHO_EN makes opcode 0x03 (ECHO) legal.
module ipg_reply_engine
  import ipg_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int MEM_DEPTH     = 16,
  parameter int MAX_MSG_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            rx_len,
  input  logic [DATA_WIDTH-1:0] rx_ipg_data,
  output logic [519:0]          ipg_reply,
  output logic                  reply_valid,
  input  logic                  reply_ready,
  output logic                  busy,
  output logic [7:0]            drop_count
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int IW = $clog2(MAX_MSG_BYTES);
  localparam int LW = $clog2(MAX_MSG_BYTES + 1);
  localparam logic [LW:0] MAX_LEN = MAX_MSG_BYTES[LW:0];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t state, state_n;
  dec_t   dec;

  logic [7:0]      msg_buf [MAX_MSG_BYTES];
  logic [LW-1:0]   msg_len;
  logic            msg_err;
  logic            rx_prev;
  logic            rx_act, msg_start, msg_append, chunk_bad, ovf;
  logic [LW-1:0]   base, payload;
  logic [LW:0]     sum;
  logic [3:0]      dec_cnt, op_cnt, cnt;
  logic [AW-1:0]   op_addr, ram_addr;
  logic            ram_we;
  logic [63:0]     ram_wdata, ram_rdata;
  logic [7:0]      rep_len;
  logic [8*MAX_MSG_BYTES-1:0] rep_bytes;

  assign rx_act     = (rx_len != 6'd0);
  // A run already in progress (e.g. one that began during REPLY) never opens a message.
  assign msg_start  = (state == ST_IDLE) && rx_act && !rx_prev;
  assign msg_append = msg_start || ((state == ST_COLLECT) && rx_act);
  assign base       = (state == ST_IDLE) ? '0 : msg_len;
  assign sum        = {1'b0, base} + {{(LW - 5){1'b0}}, rx_len};
  assign chunk_bad  = (rx_len > 6'd8);
  assign ovf        = (sum > MAX_LEN);

  assign busy        = !((state == ST_IDLE) || (state == ST_COLLECT));
  assign reply_valid = (state == ST_REPLY);
  assign ipg_reply[LEN_MSB:LEN_LSB]  = reply_valid ? rep_len : 8'd0;
  assign ipg_reply[LEN_LSB-1:0]      = reply_valid ? rep_bytes : '0;

  // Message collection
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_len    <= '0;
      msg_err    <= 1'b0;
      rx_prev    <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      rx_prev <= rx_act;
      if (msg_append) begin
        msg_err <= chunk_bad || ovf || (!msg_start && msg_err);
        msg_len <= (chunk_bad || ovf) ? base : sum[LW-1:0];
      end
      if (busy && rx_act && !rx_prev) drop_count <= sat_inc(drop_count);
    end
  end

  always_ff @(posedge clk) begin
    if (msg_append && !chunk_bad && !ovf) begin
      for (int k = 0; k < 8; k++) begin
        if (6'(k) < rx_len) msg_buf[IW'(base) + IW'(k)] <= rx_ipg_data[8*k +: 8];
      end
    end
  end

  // Request decode
  always_comb begin
    dec     = DEC_ERR;
    dec_cnt = '0;
    payload = msg_len - LW'(2);
    if (!msg_err) begin
      case (msg_buf[0])
        OP_READ: begin
          if (msg_len >= LW'(3) && msg_buf[2] >= 8'd1 && msg_buf[2] <= 8'd8) begin
            dec     = DEC_READ;
            dec_cnt = msg_buf[2][3:0];
          end
        end
        OP_WRITE: begin
          if (msg_len >= LW'(10) && payload[2:0] == 3'd0 && payload <= LW'(56)) begin
            dec     = DEC_WRITE;
            dec_cnt = payload[LW-1:3];
          end
        end
`ifdef IPG_REPLY_ECHO_EN
        OP_ECHO: dec = DEC_ECHO;
`endif
        default: dec = DEC_ERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (msg_start) state_n = ST_COLLECT;
      ST_COLLECT: if (!rx_act) state_n = ST_EXEC;
      ST_EXEC: begin
        case (dec)
          DEC_READ:  state_n = ST_MEMRD;
          DEC_WRITE: state_n = ST_MEMWR;
          default:   state_n = ST_REPLY;
        endcase
      end
      ST_MEMRD:   if (cnt == op_cnt) state_n = ST_REPLY;
      ST_MEMWR:   if (cnt == op_cnt - 4'd1) state_n = ST_REPLY;
      ST_REPLY:   if (reply_ready) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Memory access: one word per cycle, read data lands one cycle after its address
  assign ram_we   = (state == ST_MEMWR);
  assign ram_addr = op_addr + AW'(cnt);

  always_comb begin
    ram_wdata = '0;
    for (int b = 0; b < 8; b++) begin
      ram_wdata[8*b +: 8] = msg_buf[IW'(2) + IW'({cnt[2:0], 3'b000}) + IW'(b)];
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      ST_EXEC: begin
        op_addr   <= msg_buf[1][AW-1:0];
        op_cnt    <= dec_cnt;
        cnt       <= '0;
        rep_bytes <= '0;
        case (dec)
          DEC_READ:  rep_len <= {1'b0, dec_cnt, 3'b000};
          DEC_WRITE: begin
            rep_len         <= 8'd1;
            rep_bytes[7:0]  <= ACK_WRITE;
          end
`ifdef IPG_REPLY_ECHO_EN
          DEC_ECHO: begin
            rep_len <= {{(8 - LW){1'b0}}, msg_len};
            for (int k = 1; k < MAX_MSG_BYTES; k++) begin
              if (LW'(k) < msg_len) rep_bytes[8*k +: 8] <= msg_buf[k];
            end
            rep_bytes[7:0] <= ACK_ECHO;
          end
`endif
          default: begin
            rep_len        <= 8'd1;
            rep_bytes[7:0] <= ERR;
          end
        endcase
      end
      ST_MEMRD: begin
        cnt <= cnt + 4'd1;
        if (cnt != 4'd0) rep_bytes[{cnt[2:0] - 3'd1, 6'b000000} +: 64] <= ram_rdata;
      end
      ST_MEMWR: cnt <= cnt + 4'd1;
      default: ;
    endcase
  end

  ipg_word_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_WIDTH(64)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_ipg_reply_engine.sv
// Directed + randomized bench for ipg_reply_engine against a message-level reference model.
module tb_ipg_reply_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   rx_len;
  logic [63:0]  rx_ipg_data;
  logic [519:0] ipg_reply;
  logic         reply_valid;
  logic         reply_ready;
  logic         busy;
  logic [7:0]   drop_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_drop = 0;

  logic [7:0]  msg [$];
  logic [63:0] mem_m [16];

  always #5 clk = ~clk;

  ipg_reply_engine dut (
    .clk        (clk),
    .rst        (rst),
    .rx_len     (rx_len),
    .rx_ipg_data(rx_ipg_data),
    .ipg_reply  (ipg_reply),
    .reply_valid(reply_valid),
    .reply_ready(reply_ready),
    .busy       (busy),
    .drop_count (drop_count)
  );

  task automatic check(input string tag, input logic [519:0] obs, input logic [519:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference: derive reply and latency from the message bytes, updating the memory image.
  task automatic model(input bit bad, output logic [519:0] exp, output int lat);
    int len, n, w, a;
    len = msg.size();
    exp = '0;
    exp[519:512] = 8'd1;
    exp[7:0] = 8'hFF;
    lat = 2;
    if (bad || len > 64) return;
    if (msg[0] == 8'h01 && len >= 3 && msg[2] >= 8'd1 && msg[2] <= 8'd8) begin
      n = int'(msg[2]);
      a = int'(msg[1]) % 16;
      exp = '0;
      exp[519:512] = 8'(8 * n);
      for (int i = 0; i < n; i++) exp[64*i +: 64] = mem_m[(a + i) % 16];
      lat = 3 + n;
    end else if (msg[0] == 8'h02 && len >= 2 && (len - 2) > 0 && (len - 2) % 8 == 0 && (len - 2) <= 56) begin
      w = (len - 2) / 8;
      a = int'(msg[1]) % 16;
      for (int i = 0; i < w; i++)
        for (int b = 0; b < 8; b++) mem_m[(a + i) % 16][8*b +: 8] = msg[2 + 8*i + b];
      exp[7:0] = 8'h82;
      lat = 2 + w;
    end
`ifdef IPG_REPLY_ECHO_EN
    else if (msg[0] == 8'h03) begin
      exp = '0;
      exp[519:512] = 8'(len);
      for (int i = 1; i < len; i++) exp[8*i +: 8] = msg[i];
      exp[7:0] = 8'h83;
    end
`endif
  endtask

  task automatic drive_msg(input bit bad9);
    int pos, c;
    pos = 0;
    while (pos < msg.size()) begin
      c = int'($urandom_range(1, 8));
      if (c > msg.size() - pos) c = msg.size() - pos;
      @(posedge clk); #1;
      rx_len = 6'(c);
      rx_ipg_data = '0;
      for (int k = 0; k < c; k++) rx_ipg_data[8*k +: 8] = msg[pos + k];
      pos += c;
    end
    if (bad9) begin
      @(posedge clk); #1;
      rx_len = 6'd9;
      rx_ipg_data = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    rx_len = 6'd0;
    rx_ipg_data = '0;
  endtask

  // Sends msg, waits (bounded) for reply_valid, checks latency and reply; leaves the reply pending.
  task automatic run_msg(input string tag, input bit bad9, output logic [519:0] exp);
    int lat, lat_exp;
    model(bad9, exp, lat_exp);
    drive_msg(bad9);
    @(negedge clk);
    lat = 0;
    while (reply_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 520'(lat), 520'(lat_exp));
    check({tag, "_reply"}, ipg_reply, exp);
  endtask

  task automatic handshake(input string tag);
    reply_ready = 1'b1;
    @(posedge clk); #1;
    reply_ready = 1'b0;
    @(negedge clk);
    check({tag, "_clr_valid"}, 520'(reply_valid), 520'(0));
    check({tag, "_clr_reply"}, ipg_reply, 520'(0));
  endtask

  task automatic txn(input string tag, input bit bad9);
    logic [519:0] exp;
    run_msg(tag, bad9, exp);
    handshake(tag);
  endtask

  initial begin
    logic [519:0] exp;
    int r, n;
    rst = 1'b1;
    rx_len = 6'd0;
    rx_ipg_data = '0;
    reply_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 520'(reply_valid), 520'(0));
    check("rst_busy", 520'(busy), 520'(0));
    check("rst_drop", 520'(drop_count), 520'(0));
    check("rst_reply", ipg_reply, 520'(0));

    // Fill all words so every later read has a known expectation
    for (int b0 = 0; b0 < 16; b0 += 7) begin
      msg.delete();
      msg.push_back(8'h02);
      msg.push_back(8'(b0));
      n = (16 - b0 < 7) ? 16 - b0 : 7;
      for (int i = 0; i < 8 * n; i++) msg.push_back(8'($urandom));
      txn("fill", 1'b0);
    end

    msg.delete();
    msg.push_back(8'h02);
    msg.push_back(8'h03);
    for (int i = 0; i < 16; i++) msg.push_back(8'(i));
    txn("plan_wr", 1'b0);

    msg.delete();
    msg.push_back(8'h01); msg.push_back(8'h03); msg.push_back(8'h02);
    run_msg("plan_rd", 1'b0, exp);
    check("plan_rd_const", ipg_reply, {8'h10, 384'h0, 128'h0F0E0D0C0B0A09080706050403020100});
    handshake("plan_rd");

    msg.delete();
    msg.push_back(8'h02); msg.push_back(8'h0F);
    repeat (8) msg.push_back(8'hAA);
    txn("wrap_wr", 1'b0);
    msg.delete();
    msg.push_back(8'h01); msg.push_back(8'h0F); msg.push_back(8'h02);
    run_msg("wrap_rd", 1'b0, exp);
    check("wrap_lo", 520'(ipg_reply[63:0]), 520'(64'hAAAA_AAAA_AAAA_AAAA));
    handshake("wrap_rd");

    msg.delete();
    msg.push_back(8'h7E); msg.push_back(8'h00); msg.push_back(8'h01);
    run_msg("bad_op", 1'b0, exp);
    check("bad_op_const", ipg_reply, {8'h01, 504'h0, 8'hFF});
    handshake("bad_op");

    msg.delete();
    msg.push_back(8'h01); msg.push_back(8'h03); msg.push_back(8'h02);
    txn("len9", 1'b1);

    msg.delete();
    msg.push_back(8'h01); msg.push_back(8'h05); msg.push_back(8'h04);
    repeat (61) msg.push_back(8'($urandom));
    txn("len64", 1'b0);
    msg.push_back(8'($urandom));
    txn("len65", 1'b0);

    for (int t = 0; t < 25; t++) begin
      msg.delete();
      r = int'($urandom_range(0, 5));
      case (r)
        0: begin
          msg.push_back(8'h01); msg.push_back(8'($urandom));
          msg.push_back(8'($urandom_range(1, 8)));
          repeat ($urandom_range(0, 3)) msg.push_back(8'($urandom));
        end
        1: begin
          msg.push_back(8'h02); msg.push_back(8'($urandom));
          repeat (8 * $urandom_range(1, 7)) msg.push_back(8'($urandom));
        end
        2: begin
          msg.push_back(8'h02); msg.push_back(8'($urandom));
          repeat ($urandom_range(0, 62)) msg.push_back(8'($urandom));
        end
        3: begin
          msg.push_back(8'h01); msg.push_back(8'($urandom));
          msg.push_back(8'($urandom_range(0, 15)));
        end
        4: begin
          msg.push_back(8'h03);
          repeat ($urandom_range(0, 20)) msg.push_back(8'($urandom));
        end
        default: begin
          msg.push_back(8'($urandom_range(0, 3)));
          repeat ($urandom_range(0, 1)) msg.push_back(8'($urandom));
        end
      endcase
      txn("rand", 1'b0);
    end

    // Backpressure with two dropped messages, then a third started on the handshake cycle
    msg.delete();
    msg.push_back(8'h01); msg.push_back(8'h05); msg.push_back(8'h04);
    run_msg("bp", 1'b0, exp);
    for (int c = 0; c < 20; c++) begin
      rx_len = ((c >= 2 && c < 5) || (c >= 8 && c < 10)) ? 6'd8 : 6'd0;
      rx_ipg_data = {$urandom, $urandom};
      @(negedge clk);
      check("bp_hold", ipg_reply, exp);
    end
    exp_drop += 2;
    check("bp_drop", 520'(drop_count), 520'(exp_drop));
    reply_ready = 1'b1;
    rx_len = 6'd4;
    @(posedge clk); #1;
    reply_ready = 1'b0;
    exp_drop += 1;
    @(negedge clk);
    check("hs_valid", 520'(reply_valid), 520'(0));
    check("hs_busy", 520'(busy), 520'(0));
    check("hs_drop", 520'(drop_count), 520'(exp_drop));
    @(posedge clk); #1;
    rx_len = 6'd0;
    repeat (3) begin
      @(negedge clk);
      check("hs_no_start", 520'(busy), 520'(0));
    end

    // Reset while reads are in flight
    msg.delete();
    msg.push_back(8'h01); msg.push_back(8'h00); msg.push_back(8'h08);
    drive_msg(1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rmid_busy", 520'(busy), 520'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    check("rmid_valid", 520'(reply_valid), 520'(0));
    check("rmid_busy0", 520'(busy), 520'(0));
    check("rmid_drop", 520'(drop_count), 520'(exp_drop));

    msg.delete();
    msg.push_back(8'h01); msg.push_back(8'($urandom)); msg.push_back(8'($urandom_range(1, 8)));
    txn("post_rst_rd", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ipg_reply_engine.md
Name: ipg_reply_engine

Overview:
- Sits between the 10G PHY RX and TX paths, in the tx_clk domain.
- Consumes per-cycle inter-packet-gap payload chunks (rx_len, rx_ipg_data) recovered by the RX PHY and assembles them into request messages.
- Executes each request against a small local word memory.
- Presents a 520-bit reply (length byte plus 64 payload bytes) to the TX PHY under a valid/ready handshake.

Parameters:
- DATA_WIDTH, 64, chunk width; fixed at 64.
- MEM_DEPTH, 16, number of 64-bit memory words; power of 2.
- MAX_MSG_BYTES, 64, request buffer capacity in bytes.

Ports:
- clk  input  1  clock; the TX PHY clock
- rst  input  1  synchronous reset, active-high
- rx_len  input  6  valid bytes in rx_ipg_data this cycle; 0 = no data
- rx_ipg_data  input  64  chunk data; byte k at [8k+7:8k]; only the low rx_len bytes are valid
- ipg_reply  output  520  [519:512] reply length in bytes; [511:0] reply bytes, byte0 at [7:0]; unused bytes are 0
- reply_valid  output  1  ipg_reply holds a pending reply
- reply_ready  input  1  TX PHY has taken the reply
- busy  output  1  high in any state other than IDLE or COLLECT
- drop_count  output  8  saturating count of discarded messages

Behaviour:
- Reset: state=IDLE; ipg_reply=0; reply_valid=0; drop_count=0; buffer byte count=0; memory contents undefined and not cleared.
- Message framing:
  - A message is a maximal run of cycles with rx_len!=0.
  - It ends on the first cycle with rx_len==0.
  - Bytes are appended in arrival order.
- Error conditions (set a sticky per-message error; request is not executed; error reply is issued):
  - rx_len>8 in any cycle of the message.
  - Accumulated length exceeds MAX_MSG_BYTES.
- Request format:
  - byte0 = opcode; byte1 = word address; address taken modulo MEM_DEPTH.
  - READ 0x01: byte2 = word count N, 1..8. Reply length = 8N; reply bytes are words addr..addr+N-1, address wrapping modulo MEM_DEPTH, each word little-endian.
  - WRITE 0x02: bytes 2.. are data; payload length must be a non-zero multiple of 8 and at most 56. Words are written at addr, addr+1, ... with wrap. Reply = length 1, byte 0x82.
  - Any other opcode, message shorter than its header, N out of range, or bad write length → reply length 1, byte 0xFF.
- State machine:
  - IDLE: rx_len!=0 → COLLECT.
  - COLLECT: rx_len==0 → EXEC.
  - EXEC: decode. READ → MEMRD. WRITE → MEMWR. Error → REPLY.
  - MEMRD: one word per cycle; memory read is synchronous, 1-cycle latency. After N words are captured → REPLY.
  - MEMWR: one word per cycle → REPLY.
  - REPLY: reply_valid=1; ipg_reply stable. When reply_valid&&reply_ready → IDLE; clear reply_valid and ipg_reply next cycle.
- Latency, end-of-message cycle T (first rx_len==0):
  - Error reply: reply_valid at T+2.
  - READ of N words: reply_valid at T+3+N.
  - WRITE of W words: reply_valid at T+2+W.
- Messages arriving while busy=1 are not buffered. Each such run of rx_len!=0 increments drop_count once, saturating at 255.
- A message starting in the same cycle the REPLY handshake completes is dropped.
- A message of exactly 64 bytes is accepted; the 65th byte causes the overflow error.
- rst asserted mid-message or mid-reply: all state is abandoned and the block returns to reset values in the next cycle.

Optional Feature:
- Macro: IPG_REPLY_ECHO_EN.
- Defined: opcode 0x03 ECHO is legal. Reply length = message length; reply bytes = received bytes with byte0 replaced by 0x83. Reply at T+2.
- Undefined: 0x03 is an unknown opcode and produces the 0xFF error reply.

Decomposition:
- Shared package ipg_pkg holds:
  - Opcode constants: OP_READ=0x01, OP_WRITE=0x02, OP_ECHO=0x03.
  - Reply codes: ACK_WRITE=0x82, ACK_ECHO=0x83, ERR=0xFF.
  - The state enum.
  - Reply field offsets: LEN_MSB=519, LEN_LSB=512.
- One natural sub-module, ipg_word_ram: single-port synchronous RAM, MEM_DEPTH x 64, registered read.

Test Plan:
- WRITE: addr 0x03, 16 data bytes 0x00..0x0F sent as two 8-byte chunks + header chunk → reply len 1, byte 0x82 at T+4; mem[3]=0x0706050403020100, mem[4]=0x0F0E0D0C0B0A0908.
- READ after that write: addr 0x03, N=2 → reply_valid at T+5; len 0x10; ipg_reply[127:0] = 0x0F0E..0100; upper bytes 0.
- Wrap: write word 0xAA..AA at addr 15, read addr 15 N=2 → bytes 0..7 = 0xAA, bytes 8..15 = mem[0].
- Errors: opcode 0x7E → reply 0xFF. A 65-byte message → reply 0xFF. rx_len=9 → reply 0xFF.
- Backpressure/drop: hold reply_ready=0 for 20 cycles and send two messages → ipg_reply stable, drop_count=2; raise reply_ready → IDLE next cycle.
- Reset mid-MEMRD → next cycle reply_valid=0, busy=0, drop_count=0; a subsequent READ completes normally.
